rd_value_select_pipe: RTL and testbench

Parametrised, registered successor to the 2:1 Rd write-value mux in the 16-bit core's writeback path. Selects one of NSRC candidate write values. The designated immediate source is sign- or zero-extended. The selected value and destination register address pass through a valid/ready output stage with a 2-entry skid buffer, so a stalled register file never drops or duplicates a writeback. Sits between execute/MUX results and the register-file write port.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_skid_buffer.sv | 90 +++++++++
 rtl/rd_value_select_pipe.sv | 78 +++++++
 tb/tb_rd_value_select_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback value-select pipeline: default widths,
// occupancy encoding of the output stage, and a width helper.
package wb_pkg;

    localparam int WB_WIDTH = 16;
    localparam int WB_RA_W  = 4;
    localparam int WB_IMM_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Generic 2-entry valid/ready stage: a registered output slot plus one skid
// slot that catches the beat arriving in the same cycle as a stall.
module wb_skid_buffer
    import wb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    occ_e       state, state_nx;
    logic [W-1:0] out_q, skid_q;
    logic       in_ready_q;
    logic       accept, handshake;
    logic       load_out, load_skid, out_from_skid;

    assign accept    = in_valid && in_ready_q;
    assign handshake = out_valid && out_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx      = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) begin
                    load_out = 1'b1;
                    state_nx = ST_ONE;
                end
                ST_ONE: if (handshake && accept) begin
                    load_out = 1'b1;
                end else if (handshake) begin
                    state_nx = ST_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nx  = ST_FULL;
                end
                ST_FULL: if (handshake) begin
                    out_from_skid = 1'b1;
                    state_nx      = ST_ONE;
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nx;
            // Derived from next state, so ready drops exactly when FULL is entered.
            in_ready_q <= (state_nx != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (load_out) begin
            out_q <= in_data;
        end else if (out_from_skid) begin
            out_q <= skid_q;
        end
    end

    // NOTE: the skid slot is never read unless FULL, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_skid) skid_q <= in_data;
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_q;
    assign out_valid = (state != ST_EMPTY);

endmodule

// File: rtl/rd_value_select_pipe.sv
// Registered Rd write-value select: picks one of NSRC candidates (one of them an
// extended immediate) and hands it to the register file through a skid stage.
module rd_value_select_pipe
    import wb_pkg::*;
#(
    parameter int WIDTH   = WB_WIDTH,
    parameter int NSRC    = 4,
    parameter int SEL_W   = 2,
    parameter int IMM_SRC = 1,
    parameter int IMM_W   = WB_IMM_W,
    parameter int RA_W    = WB_RA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  imm_sign,
    input  logic [RA_W-1:0]       rd_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      wb_data,
    output logic [RA_W-1:0]       wb_addr,
    output logic                  wb_err,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  err_sticky
);

    localparam int PW = WIDTH + RA_W + 1;

    logic [31:0]      sel_ext;
    logic [IMM_W-1:0] imm_raw;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] sel_value;
    logic             sel_err;

    assign sel_ext = 32'(sel);
    assign imm_raw = src_data[IMM_SRC*WIDTH +: IMM_W];

    if (IMM_W < WIDTH) begin : g_imm_extend
        assign imm_ext = {{(WIDTH-IMM_W){imm_sign & imm_raw[IMM_W-1]}}, imm_raw};
    end else begin : g_imm_full
        assign imm_ext = imm_raw;
    end

    always_comb begin
        sel_value = '0;
        sel_err   = (sel_ext >= 32'(NSRC));
        for (int i = 0; i < NSRC; i++) begin
            if (sel_ext == 32'(i)) sel_value = src_data[i*WIDTH +: WIDTH];
        end
        if (sel_ext == 32'(IMM_SRC)) sel_value = imm_ext;
    end

    wb_skid_buffer #(.W(PW)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_data  ({sel_err, rd_addr, sel_value}),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data ({wb_err, wb_addr, wb_data}),
        .out_valid(wb_valid),
        .out_ready(wb_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (flush) begin
            err_sticky <= 1'b0;
        end else if (in_valid && in_ready && sel_err) begin
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rd_value_select_pipe.sv
// Directed bench for rd_value_select_pipe: vector table for select/extend,
// hand sequences for backpressure, flush, mid-stall reset and out-of-range sel.
module tb_rd_value_select_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] src_data;
    logic [1:0]  sel;
    logic        imm_sign;
    logic [3:0]  rd_addr;
    logic        in_valid, in_ready, flush;
    logic [15:0] wb_data;
    logic [3:0]  wb_addr;
    logic        wb_err, wb_valid, wb_ready, err_sticky;

    logic [47:0] e_src_data;
    logic [1:0]  e_sel;
    logic        e_in_valid, e_in_ready, e_flush;
    logic [15:0] e_wb_data;
    logic [3:0]  e_wb_addr;
    logic        e_wb_err, e_wb_valid, e_wb_ready, e_err_sticky;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] log_q[$];

    always #5 clk = ~clk;

    rd_value_select_pipe dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .sel(sel), .imm_sign(imm_sign),
        .rd_addr(rd_addr), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .wb_data(wb_data), .wb_addr(wb_addr), .wb_err(wb_err), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .err_sticky(err_sticky)
    );

    rd_value_select_pipe #(.NSRC(3), .SEL_W(2)) dut_e (
        .clk(clk), .rst_n(rst_n), .src_data(e_src_data), .sel(e_sel), .imm_sign(1'b0),
        .rd_addr(4'd9), .in_valid(e_in_valid), .in_ready(e_in_ready), .flush(e_flush),
        .wb_data(e_wb_data), .wb_addr(e_wb_addr), .wb_err(e_wb_err), .wb_valid(e_wb_valid),
        .wb_ready(e_wb_ready), .err_sticky(e_err_sticky)
    );

    // Completed output handshakes of the main instance, sampled mid-cycle.
    always @(negedge clk) if (rst_n && wb_valid && wb_ready) log_q.push_back(wb_data);

    typedef struct {
        logic [1:0]  sel;
        logic [63:0] src;
        logic        imm_sign;
        logic [3:0]  rd;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d0, input logic [3:0] rd);
        sel      = 2'd0;
        src_data = {48'h0, d0};
        rd_addr  = rd;
        in_valid = 1'b1;
    endtask

    initial begin
        vecs[0] = '{2'd0, {16'hDDDD, 16'hCCCC, 16'h00F0, 16'h1234}, 1'b0, 4'd5, 16'h1234};
        vecs[1] = '{2'd2, {16'hDDDD, 16'hCCCC, 16'h00F0, 16'h1234}, 1'b0, 4'd6, 16'hCCCC};
        vecs[2] = '{2'd3, {16'hDDDD, 16'hCCCC, 16'h00F0, 16'h1234}, 1'b0, 4'd7, 16'hDDDD};
        vecs[3] = '{2'd1, {16'hDDDD, 16'hCCCC, 16'h00F0, 16'h1234}, 1'b1, 4'd1, 16'hFFF0};
        vecs[4] = '{2'd1, {16'hDDDD, 16'hCCCC, 16'h00F0, 16'h1234}, 1'b0, 4'd2, 16'h00F0};
        vecs[5] = '{2'd1, {16'hDDDD, 16'hCCCC, 16'hAB70, 16'h1234}, 1'b1, 4'd3, 16'h0070};
        vecs[6] = '{2'd1, {16'hDDDD, 16'hCCCC, 16'h1280, 16'h1234}, 1'b1, 4'd4, 16'hFF80};
        vecs[7] = '{2'd1, {16'hDDDD, 16'hCCCC, 16'h1280, 16'h1234}, 1'b0, 4'd8, 16'h0080};
        vecs[8] = '{2'd0, {16'hDDDD, 16'hCCCC, 16'h1280, 16'h8000}, 1'b1, 4'd15, 16'h8000};

        rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1; imm_sign = 1'b0;
        drive(16'hBEEF, 4'd3);
        e_src_data = '0; e_sel = 2'd0; e_in_valid = 1'b0; e_flush = 1'b0; e_wb_ready = 1'b1;
        step(); step();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 16'h0000);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_err", wb_err, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_sticky", err_sticky, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Back-to-back beats with wb_ready high: one output per cycle.
        for (int i = 0; i < 9; i++) begin
            sel = vecs[i].sel; src_data = vecs[i].src; imm_sign = vecs[i].imm_sign;
            rd_addr = vecs[i].rd; in_valid = 1'b1;
            step();
            check($sformatf("vec%0d_valid", i), wb_valid, 1);
            check($sformatf("vec%0d_data", i), wb_data, vecs[i].exp_data);
            check($sformatf("vec%0d_addr", i), wb_addr, vecs[i].rd);
            check($sformatf("vec%0d_err", i), wb_err, 0);
        end
        in_valid = 1'b0; imm_sign = 1'b0;
        step();
        check("drain_valid", wb_valid, 0);

        // Backpressure: A, B fill the stage, C waits at the input.
        log_q.delete();
        wb_ready = 1'b0;
        drive(16'h1111, 4'd1); step();
        check("bp_a_data", wb_data, 16'h1111);
        check("bp_a_in_ready", in_ready, 1);
        drive(16'h2222, 4'd2); step();
        check("bp_full_in_ready", in_ready, 0);
        drive(16'h3333, 4'd3); step();
        check("bp_stall_in_ready", in_ready, 0);
        check("bp_stall_data", wb_data, 16'h1111);
        check("bp_stall_addr", wb_addr, 1);
        wb_ready = 1'b1; step();
        check("bp_b_data", wb_data, 16'h2222);
        check("bp_b_in_ready", in_ready, 1);
        step();
        check("bp_c_data", wb_data, 16'h3333);
        check("bp_c_addr", wb_addr, 3);
        in_valid = 1'b0; step(); step();
        check("bp_empty_valid", wb_valid, 0);
        check("bp_log_len", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("bp_log0", log_q[0], 16'h1111);
            check("bp_log1", log_q[1], 16'h2222);
            check("bp_log2", log_q[2], 16'h3333);
        end

        // Flush in FULL discards both held beats and the one presented with it.
        log_q.delete();
        wb_ready = 1'b0;
        drive(16'h5555, 4'd5); step();
        drive(16'h6666, 4'd6); step();
        check("fl_full_in_ready", in_ready, 0);
        flush = 1'b1; drive(16'h4444, 4'd4); step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_wb_valid", wb_valid, 0);
        check("fl_in_ready", in_ready, 1);
        wb_ready = 1'b1; step(); step(); step();
        check("fl_still_empty", wb_valid, 0);
        check("fl_log_len", log_q.size(), 0);

        // Asynchronous reset while FULL and stalled.
        wb_ready = 1'b0;
        drive(16'h7777, 4'd7); step();
        drive(16'h8888, 4'd8); step();
        check("mr_full_in_ready", in_ready, 0);
        drive(16'h9999, 4'd9);
        #1 rst_n = 1'b0; log_q.delete();
        #1;
        check("mr_wb_valid", wb_valid, 0);
        check("mr_wb_data", wb_data, 16'h0000);
        check("mr_wb_addr", wb_addr, 0);
        check("mr_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;
        step();
        check("mr_new_data", wb_data, 16'h9999);
        wb_ready = 1'b1; in_valid = 1'b0;
        step(); step();
        check("mr_log_len", log_q.size(), 1);
        if (log_q.size() == 1) check("mr_log0", log_q[0], 16'h9999);

        // Out-of-range sel on the NSRC = 3 instance.
        e_src_data = {16'h5A5A, 16'h00F0, 16'h1234};
        e_sel = 2'd3; e_in_valid = 1'b1; step();
        check("oor_valid", e_wb_valid, 1);
        check("oor_data", e_wb_data, 16'h0000);
        check("oor_err", e_wb_err, 1);
        check("oor_sticky", e_err_sticky, 1);
        e_sel = 2'd2; step();
        check("oor_src2_data", e_wb_data, 16'h5A5A);
        check("oor_src2_err", e_wb_err, 0);
        check("oor_sticky_held", e_err_sticky, 1);
        e_in_valid = 1'b0; e_flush = 1'b1; step();
        e_flush = 1'b0;
        check("oor_flush_clears", e_err_sticky, 0);
        e_sel = 2'd3; e_in_valid = 1'b1; e_flush = 1'b1; step();
        e_flush = 1'b0; e_in_valid = 1'b0;
        check("oor_flush_wins_sticky", e_err_sticky, 0);
        check("oor_flush_wins_valid", e_wb_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
